// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridgeState;

    localparam int          TIMEOUT_DEFAULT = 255;
    localparam int          TO_W_DEFAULT    = 8;
    localparam logic [31:0] WORD_ALIGN      = 32'hFFFF_FFFC;

    // Byte address to the word address presented on the bus.
    function automatic logic [31:0] wordAddr(input logic [31:0] byteAddr);
        return byteAddr & WORD_ALIGN;
    endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// One-entry posted store buffer; used only when DMEM_STORE_BUFFER_EN is defined.
module dmem_store_buf
    import dmem_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [3:0]  pushWe,
    input  logic [31:0] pushAddr,
    input  logic [31:0] pushData,
    output logic        valid,
    output logic [3:0]  entryWe,
    output logic [31:0] entryAddr,
    output logic [31:0] entryData
);

    // Capture a store on push, release the entry once its drain completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            entryWe   <= 4'b0;
            entryAddr <= 32'b0;
            entryData <= 32'b0;
        end else if (push) begin
            valid     <= 1'b1;
            entryWe   <= pushWe;
            entryAddr <= wordAddr(pushAddr);
            entryData <= pushData;
        end else if (pop) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: turns core load/store requests into req/ack bus
// transactions and stalls the pipeline until each one completes.
// Optional feature macro: DMEM_STORE_BUFFER_EN (one-entry posted store buffer).
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = TO_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoregM,
    input  logic [3:0]  memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        bus_err,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    bridgeState      state;
    bridgeState      nextState;
    logic [TO_W-1:0] toCount;
    logic [31:0]     rdataQ;
    logic            acc;
    logic            atLimit;
    logic            finishReq;
    logic            startCore;
    logic            draining;

    assign acc       = memtoregM | (|memwriteM);
    assign atLimit   = (toCount == TO_W'(TIMEOUT));
    assign finishReq = (state == REQ) && (mem_ack || atLimit);
    assign readdataM = rdataQ;

`ifdef DMEM_STORE_BUFFER_EN
    logic        startDrain;
    logic        bufPush;
    logic        bufPop;
    logic        bufValid;
    logic [3:0]  bufWe;
    logic [31:0] bufAddr;
    logic [31:0] bufData;

    assign bufPop = finishReq && draining;

    dmem_store_buf uStoreBuf (
        .clk       (clk),
        .rst       (rst),
        .push      (bufPush),
        .pop       (bufPop),
        .pushWe    (memwriteM),
        .pushAddr  (aluoutM),
        .pushData  (writedataM),
        .valid     (bufValid),
        .entryWe   (bufWe),
        .entryAddr (bufAddr),
        .entryData (bufData)
    );

    // Remember whether the bus transaction in flight is a buffer drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            draining <= 1'b0;
        end else if (startDrain) begin
            draining <= 1'b1;
        end else if (startCore) begin
            draining <= 1'b0;
        end
    end
`else
    assign draining = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and pipeline stall; a drain only stalls a waiting access.
    always_comb begin
        nextState = state;
        stallM    = 1'b0;
        startCore = 1'b0;
`ifdef DMEM_STORE_BUFFER_EN
        startDrain = 1'b0;
        bufPush    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef DMEM_STORE_BUFFER_EN
                if (bufValid) begin
                    startDrain = 1'b1;
                    nextState  = REQ;
                    stallM     = acc;
                end else if (|memwriteM) begin
                    bufPush = 1'b1;
                end else if (acc) begin
                    startCore = 1'b1;
                    nextState = REQ;
                    stallM    = 1'b1;
                end
`else
                if (acc) begin
                    startCore = 1'b1;
                    nextState = REQ;
                    stallM    = 1'b1;
                end
`endif
            end
            REQ: begin
                stallM = draining ? acc : 1'b1;
                if (finishReq) begin
                    nextState = draining ? IDLE : DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Bus registers, returned data, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 4'b0;
            mem_addr  <= 32'b0;
            mem_wdata <= 32'b0;
            rdataQ    <= 32'b0;
            bus_err   <= 1'b0;
            toCount   <= '0;
        end else if (startCore) begin
            mem_req   <= 1'b1;
            mem_we    <= memwriteM;
            mem_addr  <= wordAddr(aluoutM);
            mem_wdata <= writedataM;
            toCount   <= '0;
`ifdef DMEM_STORE_BUFFER_EN
        end else if (startDrain) begin
            mem_req   <= 1'b1;
            mem_we    <= bufWe;
            mem_addr  <= bufAddr;
            mem_wdata <= bufData;
            toCount   <= '0;
`endif
        end else if (state == REQ) begin
            if (mem_ack) begin
                mem_req <= 1'b0;
                if (mem_we == 4'b0 && !draining) begin
                    rdataQ <= mem_rdata;
                end
            end else if (atLimit) begin
                mem_req <= 1'b0;
                bus_err <= 1'b1;
                if (!draining) begin
                    rdataQ <= 32'b0;
                end
            end else begin
                toCount <= toCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus a random
// mix of loads, stores and idle slots, judged against a word-level memory model.
module tb_dmem_bridge;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        memtoregM;
    logic [3:0]  memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        bus_err;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // RAM contents as seen through the bus, and the reference model of memory.
    logic [31:0] busRam   [int];
    logic [31:0] modelMem [int];
    logic [31:0] lastRead = 32'b0;
    logic        expErr   = 1'b0;

    dmem_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stallM     (stallM),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        return 32'(idx) * 32'h9E37_79B9 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [3:0] we,
                                               input logic [31:0] data);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] busRead(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        return busRam.exists(idx) ? busRam[idx] : initWord(idx);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int idx;
        idx = int'(addr >> 2);
        return modelMem.exists(idx) ? modelMem[idx] : initWord(idx);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one M-stage instruction, act as the RAM (ack k cycles after the
    // request rises, k<0 means never), and check latency, bus fields and results.
    task automatic applyStimulus(input bit isLoad, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int k);
        int cyc, stalls, reqCycles, reqRises, expStalls;
        bit done, acc, prevReq;
        logic [31:0] expAddr;
        acc       = isLoad || (we != 4'b0);
        expAddr   = addr & 32'hFFFF_FFFC;
        cyc       = 0;
        stalls    = 0;
        reqCycles = 0;
        reqRises  = 0;
        done      = 1'b0;
        prevReq   = 1'b0;
        @(negedge clk);
        memtoregM  = isLoad;
        memwriteM  = we;
        aluoutM    = addr;
        writedataM = wdata;
        while (!done && cyc < 400) begin
            if (cyc != 0) @(negedge clk);
            if (mem_req) begin
                if (!prevReq) reqRises++;
                if (reqCycles == 0) begin
                    checkOutput("memAddr", mem_addr, expAddr);
                    checkOutput("memWe", 32'(mem_we), 32'(we));
                    if (we != 4'b0) checkOutput("memWdata", mem_wdata, wdata);
                end
                mem_ack   = (k >= 0 && reqCycles == k);
                mem_rdata = (mem_ack && mem_we == 4'b0) ? busRead(mem_addr) : $urandom;
                if (mem_ack && mem_we != 4'b0) begin
                    busRam[int'(mem_addr >> 2)] = mergeBytes(busRead(mem_addr), mem_we, mem_wdata);
                end
                reqCycles++;
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            prevReq = mem_req;
            #1;
            cyc++;
            if (stallM) stalls++;
            else done = 1'b1;
        end
        expStalls = !acc ? 0 : (k < 0 ? TIMEOUT + 2 : k + 2);
        checkOutput("stallCycles", 32'(stalls), 32'(expStalls));
        checkOutput("accessCycles", 32'(cyc), 32'(expStalls + 1));
        checkOutput("requestCount", 32'(reqRises), acc ? 32'd1 : 32'd0);
        if (acc) begin
            checkOutput("reqLowAtDone", 32'(mem_req), 32'd0);
            if (k < 0) begin
                lastRead = 32'b0;
                expErr   = 1'b1;
            end else if (we != 4'b0) begin
                modelMem[int'(addr >> 2)] = mergeBytes(modelRead(addr), we, wdata);
            end else begin
                lastRead = modelRead(addr);
            end
        end
        checkOutput("readdataM", readdataM, lastRead);
        checkOutput("busErr", 32'(bus_err), 32'(expErr));
    endtask

    int          sbStalls;
    int          sbCyc;
    int          sbReqCycles;
    bit          sbDone;
    bit          sbPrevReq;
    logic [31:0] sbWord = 32'b0;

    initial begin
        rst        = 1'b1;
        memtoregM  = 1'b0;
        memwriteM  = 4'b0;
        aluoutM    = 32'b0;
        writedataM = 32'b0;
        mem_rdata  = 32'b0;
        mem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstStall", 32'(stallM), 32'd0);
        checkOutput("rstReq", 32'(mem_req), 32'd0);
        checkOutput("rstWe", 32'(mem_we), 32'd0);
        checkOutput("rstAddr", mem_addr, 32'd0);
        checkOutput("rstWdata", mem_wdata, 32'd0);
        checkOutput("rstRead", readdataM, 32'd0);
        checkOutput("rstErr", 32'(bus_err), 32'd0);
        rst = 1'b0;

`ifdef DMEM_STORE_BUFFER_EN
        // Posted store followed by a load that must wait for the drain.
        @(negedge clk);
        memwriteM  = 4'hF;
        aluoutM    = 32'h80;
        writedataM = 32'hCAFE_F00D;
        #1;
        checkOutput("sbStoreStall", 32'(stallM), 32'd0);
        sbStalls = 0; sbCyc = 0; sbReqCycles = 0; sbDone = 1'b0; sbPrevReq = 1'b0;
        @(negedge clk);
        memwriteM = 4'b0;
        memtoregM = 1'b1;
        while (!sbDone && sbCyc < 100) begin
            if (sbCyc != 0) @(negedge clk);
            if (mem_req) begin
                if (!sbPrevReq) sbReqCycles = 0;
                mem_ack   = (sbReqCycles == ((mem_we != 4'b0) ? 5 : 0));
                mem_rdata = sbWord;
                if (mem_ack && mem_we != 4'b0) sbWord = mem_wdata;
                sbReqCycles++;
            end else begin
                mem_ack = 1'b0;
            end
            sbPrevReq = mem_req;
            #1;
            sbCyc++;
            if (stallM) sbStalls++;
            else sbDone = 1'b1;
        end
        checkOutput("sbLoadStalls", 32'(sbStalls), 32'd9);
        checkOutput("sbLoadData", readdataM, 32'hCAFE_F00D);
        checkOutput("sbErr", 32'(bus_err), 32'd0);
`else
        // Directed: load with ack after 2 cycles returning 0xDEADBEEF.
        busRam[4]   = 32'hDEAD_BEEF;
        modelMem[4] = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 4'b0000, 32'h0000_0013, 32'h0, 2);
        checkOutput("t1Data", readdataM, 32'hDEAD_BEEF);
        // Directed: half-word store acked immediately.
        applyStimulus(1'b0, 4'b0011, 32'h0000_0020, 32'h0000_1234, 0);
        // Directed: load then store back to back, k=1 each.
        applyStimulus(1'b1, 4'b0000, 32'h0000_0022, 32'h0, 1);
        applyStimulus(1'b0, 4'b1100, 32'h0000_0024, 32'hABCD_0000, 1);
        // Load with byte enables set behaves as a store.
        applyStimulus(1'b1, 4'b0100, 32'h0000_0030, 32'h0077_0000, 2);

        // Random mix of idle slots, loads and stores over a small address window.
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [3:0] rwe;
            sel = $urandom_range(0, 9);
            rwe = 4'($urandom_range(1, 15));
            if (sel < 2)      applyStimulus(1'b0, 4'b0, 32'($urandom_range(0, 127)), $urandom, 0);
            else if (sel < 6) applyStimulus(1'b1, 4'b0, 32'($urandom_range(0, 127)), $urandom,
                                            $urandom_range(0, 4));
            else if (sel < 9) applyStimulus(1'b0, rwe, 32'($urandom_range(0, 127)), $urandom,
                                            $urandom_range(0, 4));
            else              applyStimulus(1'b1, rwe, 32'($urandom_range(0, 127)), $urandom,
                                            $urandom_range(0, 4));
        end

        // Timeout: no ack ever; bus_err must stick across later accesses.
        applyStimulus(1'b1, 4'b0000, 32'h0000_0044, 32'h0, -1);
        applyStimulus(1'b0, 4'b1111, 32'h0000_0048, 32'h5555_AAAA, 1);
        applyStimulus(1'b1, 4'b0000, 32'h0000_0048, 32'h0, 0);

        // Reset during the second REQ cycle, then a late ack that must be ignored.
        @(negedge clk);
        memtoregM = 1'b1;
        memwriteM = 4'b0;
        aluoutM   = 32'h0000_0060;
        mem_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        memtoregM = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        checkOutput("t5ReqDrop", 32'(mem_req), 32'd0);
        checkOutput("t5Stall", 32'(stallM), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checkOutput("t5ReqIdle", 32'(mem_req), 32'd0);
        checkOutput("t5Read", readdataM, 32'd0);
        checkOutput("t5ErrClr", 32'(bus_err), 32'd0);
        lastRead = 32'b0;
        expErr   = 1'b0;
        applyStimulus(1'b1, 4'b0000, 32'h0000_0022, 32'h0, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
